qoa_slice_unpacker: RTL
=======================

Name: qoa_slice_unpacker

Overview:
- Sits directly downstream of the SPI receive path, which delivers one byte per single-cycle `byte_valid` pulse in the `sys_clk` domain.
- Assembles 8 consecutive bytes into one 64-bit big-endian QOA slice, then emits its 20 residuals in order.
- Each residual is dequantised to a signed 16-bit value through a valid/ready handshake to the LMS predictor stage.
- Double-buffered: the next slice can be received while the current one drains.

Parameters:
- NUM_RES, 20, residuals per slice (fixed by the QOA format; not meant to be overridden).
- SLICE_BYTES, 8, bytes per slice.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- byte_valid  input  1  single-cycle pulse; byte_in is valid this cycle. No backpressure.
- byte_in  input  8  received byte, MSB first in slice order.
- slice_sync  input  1  pulse; discards any partially assembled slice (byte counter to 0).
- res_valid  output  1  res_data valid.
- res_ready  input  1  consumer accepts when res_valid && res_ready.
- res_data  output  16  signed dequantised residual.
- res_index  output  5  residual index 0..19 of the current res_data.
- res_last  output  1  high when res_index == 19.
- sf_index  output  4  scalefactor index of the slice currently being emitted.
- overflow  output  1  sticky; a completed slice was dropped.

Behaviour:
- Reset (async, sys_rst_n low) values:
  - Byte counter = 0, assembly register = 0, holding register = 0, holding_full = 0.
  - res_valid = 0, res_index = 0, overflow = 0.
  - res_data = 0, res_last = 0, sf_index = 0 (all combinational from cleared registers).
- Reset mid-slice aborts both the assembly and the emission; no residual is emitted afterwards.
- Assembly:
  - On byte_valid: assembly <= {assembly[55:0], byte_in}; byte_cnt increments.
  - On the 8th byte: slice_complete; byte_cnt wraps to 0.
  - slice_sync clears byte_cnt. If slice_sync and byte_valid coincide, slice_sync wins and the byte is dropped.
- Holding register, FSM states EMPTY and EMIT:
  - EMPTY -> EMIT on slice_complete: holding <= completed 64 bits, res_index <= 0, res_valid = 1.
  - res_valid rises the cycle after the cycle carrying the 8th byte_valid (latency 1).
  - In EMIT, each accepted transfer increments res_index.
  - Accept at res_index 19 -> EMPTY, unless slice_complete occurs in the same cycle. In that case, reload and stay in EMIT with res_index 0. No bubble, no drop.
  - slice_complete in EMIT without the final accept: the new slice is discarded, overflow <= 1, current emission unaffected.
  - overflow clears only on reset.
- Field extraction:
  - sf_index = holding[63:60].
  - Residual k: q = holding[59-3k -: 3].
- Dequantisation (combinational from registers; stable while res_valid && !res_ready):
  - sf = round((s+1)^2.75) table: 1,7,21,45,84,138,211,304,421,562,731,928,1157,1419,1715,2048.
  - Magnitude by q>>1: 0 -> (3sf+2)>>2; 1 -> (5sf+1)>>1; 2 -> (9sf+1)>>1; 3 -> 7sf.
  - Even q gives a positive value; odd q gives the negated magnitude.
  - Intermediates are at least 15 bits unsigned. Maximum |res_data| = 14336, so no saturation is needed.
- res_valid never drops without a handshake, except on reset.
- res_data, res_index and sf_index are held while stalled.

Test Plan:
- Reset, then bytes 6E 00 00 00 00 00 00 00 with res_ready = 1:
  - res_valid rises 1 cycle after the 8th byte; sf_index = 6.
  - res_data idx0 = -1477 (0xFA3B); idx1..19 = +158.
  - res_last only on idx19; then FSM returns to EMPTY.
- Slice FF×8:
  - All 20 outputs = -14336 (0xC800), sf_index = 15.
- Stall: res_ready = 0 for 10 cycles at idx 5:
  - res_valid, res_data and res_index stay constant.
  - After release, idx 6 follows; exactly 20 transfers total.
- Back-to-back:
  - Second slice completes on the same cycle idx19 is accepted -> next cycle shows idx0 of the second slice, no gap, overflow = 0.
  - Second variant: res_ready = 0 throughout, then a second slice completes -> overflow = 1 and is sticky. First slice still emits fully; the second is never emitted.
- slice_sync after 3 bytes, then 8 new bytes:
  - Output reflects only the 8 new bytes.
  - Assert sys_rst_n low mid-emission at idx 10: res_valid = 0 immediately (async); no further output until a new full slice arrives.

Source files
------------

// File: rtl/qoa_slice_unpacker.sv
// QOA slice unpacker: gathers 8 bytes into a 64-bit big-endian slice and
// streams its 20 dequantised residuals over a valid/ready handshake.
// One slice is held for emission while the next one assembles.
module qoa_slice_unpacker #(
    parameter int unsigned NUM_RES     = 20,
    parameter int unsigned SLICE_BYTES = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        slice_sync,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [4:0]  res_index,
    output logic        res_last,
    output logic [3:0]  sf_index,
    output logic        overflow
);

    localparam int unsigned CntW = $clog2(SLICE_BYTES);
    localparam logic [CntW-1:0] LastByte = CntW'(SLICE_BYTES - 1);
    localparam logic [4:0] LastIdx = 5'(NUM_RES - 1);

    typedef enum logic [0:0] {StEmpty, StEmit} state_e;

    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [63:0]     assembly_q, assembly_d;
    logic [63:0]     holding_q, holding_d;
    logic [4:0]      res_index_q, res_index_d;
    logic            overflow_q, overflow_d;
    state_e          state_q, state_d;

    logic        slice_complete;
    logic [63:0] completed;
    logic        accept;

    // Byte assembly; slice_sync has priority and drops a coincident byte.
    always_comb begin
        byte_cnt_d     = byte_cnt_q;
        assembly_d     = assembly_q;
        slice_complete = 1'b0;
        completed      = {assembly_q[55:0], byte_in};
        if (slice_sync) begin
            byte_cnt_d = '0;
        end else if (byte_valid) begin
            assembly_d = completed;
            if (byte_cnt_q == LastByte) begin
                byte_cnt_d     = '0;
                slice_complete = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end
    end

    assign accept = (state_q == StEmit) && res_ready;

    // Holding-register FSM: load, step through residuals, flag dropped slices.
    always_comb begin
        state_d     = state_q;
        holding_d   = holding_q;
        res_index_d = res_index_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            StEmpty: begin
                if (slice_complete) begin
                    holding_d   = completed;
                    res_index_d = '0;
                    state_d     = StEmit;
                end
            end
            StEmit: begin
                if (accept && res_index_q == LastIdx) begin
                    res_index_d = '0;
                    if (slice_complete) begin
                        holding_d = completed;
                    end else begin
                        state_d = StEmpty;
                    end
                end else begin
                    if (accept) begin
                        res_index_d = res_index_q + 1'b1;
                    end
                    if (slice_complete) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // State registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_cnt_q  <= '0;
            assembly_q  <= '0;
            holding_q   <= '0;
            res_index_q <= '0;
            overflow_q  <= 1'b0;
            state_q     <= StEmpty;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            assembly_q  <= assembly_d;
            holding_q   <= holding_d;
            res_index_q <= res_index_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
        end
    end

    logic [5:0]  q_lo;
    logic [2:0]  q;
    logic [15:0] sf_val;
    logic [15:0] mag;

    // Field extraction and dequantisation of the current residual.
    always_comb begin
        q_lo = 6'd57 - ({1'b0, res_index_q} + {res_index_q, 1'b0});
        q    = holding_q[q_lo +: 3];
        unique case (holding_q[63:60])
            4'd0:    sf_val = 16'd1;
            4'd1:    sf_val = 16'd7;
            4'd2:    sf_val = 16'd21;
            4'd3:    sf_val = 16'd45;
            4'd4:    sf_val = 16'd84;
            4'd5:    sf_val = 16'd138;
            4'd6:    sf_val = 16'd211;
            4'd7:    sf_val = 16'd304;
            4'd8:    sf_val = 16'd421;
            4'd9:    sf_val = 16'd562;
            4'd10:   sf_val = 16'd731;
            4'd11:   sf_val = 16'd928;
            4'd12:   sf_val = 16'd1157;
            4'd13:   sf_val = 16'd1419;
            4'd14:   sf_val = 16'd1715;
            default: sf_val = 16'd2048;
        endcase
        unique case (q[2:1])
            2'd0:    mag = (sf_val * 16'd3 + 16'd2) >> 2;
            2'd1:    mag = (sf_val * 16'd5 + 16'd1) >> 1;
            2'd2:    mag = (sf_val * 16'd9 + 16'd1) >> 1;
            default: mag = sf_val * 16'd7;
        endcase
    end

    assign res_valid = (state_q == StEmit);
    // Gated so the idle/reset value reads as zero rather than the q=0 magnitude.
    assign res_data  = !res_valid ? 16'd0 : (q[0] ? (16'd0 - mag) : mag);
    assign res_index = res_index_q;
    assign res_last  = (res_index_q == LastIdx);
    assign sf_index  = holding_q[63:60];
    assign overflow  = overflow_q;

endmodule
